// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch front end.
package riscv_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: synchronous active-low reset, load, and +4 increment.
module pc_reg #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] load_val,
    input  logic            inc,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_VECTOR;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + XLEN'(4);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one outstanding imem request,
// and hands fetched instructions to decode over a valid/ready handshake.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_misaligned
);

    fetch_state_e    state_q, state_d;
    logic            squash_q, squash_d;
    logic            pc_inc;
    logic            capture;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirect_aligned;

    assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    pc_reg #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (redirect_valid),
        .load_val (redirect_aligned),
        .inc      (pc_inc),
        .pc       (pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= REQ;
            squash_q         <= 1'b0;
            instr            <= XLEN'(NOP_INSTR);
            instr_pc         <= RESET_VECTOR;
            fetch_misaligned <= 1'b0;
        end else begin
            state_q          <= state_d;
            squash_q         <= squash_d;
            fetch_misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (capture) begin
                instr    <= imem_rsp_data;
                instr_pc <= pc;
            end
        end
    end

    // Redirect wins everywhere: an accepted request or a pending response is
    // marked stale via squash, and a buffered instruction is abandoned.
    always_comb begin
        state_d  = state_q;
        squash_d = squash_q;
        pc_inc   = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            REQ: begin
                if (imem_req_ready) begin
                    state_d  = WAIT;
                    squash_d = redirect_valid;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_d  = REQ;
                    squash_d = 1'b0;
                    if (!squash_q && !redirect_valid) begin
                        capture = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = HOLD;
                    end
                end else if (redirect_valid) begin
                    squash_d = 1'b1;
                end
            end
            HOLD: begin
                if (instr_ready || redirect_valid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    assign imem_req_valid = rst_n && (state_q == REQ);
    assign imem_req_addr  = pc;
    assign instr_valid    = (state_q == HOLD);

endmodule
